// File: rtl/cmd_resp_router.sv
`default_nettype none
// ============================================================================
// Module      : cmd_resp_router
// Description : Routes custom-instruction commands to the tinyML accelerator
//               or the user custom-instruction unit and returns their
//               responses to the CPU strictly in command-issue order.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_resp_router #(
    parameter int OUTSTANDING_DEPTH = 4,
    parameter int FUNC_SEL_BIT      = 9,
    parameter int CNT_W             = $clog2(OUTSTANDING_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [9:0]        cmd_function_id,
    output logic              cmd_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_outputs_0,
    input  logic              rsp_ready,
    output logic              accel_cmd_valid,
    input  logic              accel_cmd_ready,
    input  logic              accel_rsp_valid,
    input  logic [31:0]       accel_rsp_outputs_0,
    output logic              accel_rsp_ready,
    output logic              user_cmd_valid,
    input  logic              user_cmd_ready,
    input  logic              user_rsp_valid,
    input  logic [31:0]       user_rsp_outputs_0,
    output logic              user_rsp_ready,
    output logic [CNT_W-1:0]  outstanding_cnt,
    output logic              err_unexpected_rsp,
    input  logic              err_clear
);

    localparam int c_PTR_W = $clog2(OUTSTANDING_DEPTH);

    // Tag FIFO: one bit per outstanding command, 1 = user unit, 0 = accel.
    logic [OUTSTANDING_DEPTH-1:0] r_tag;
    logic [c_PTR_W-1:0]           r_wr_ptr;
    logic [c_PTR_W-1:0]           r_rd_ptr;
    logic [CNT_W-1:0]             r_cnt;
    logic                         r_err;

    logic w_sel;
    logic w_full;
    logic w_empty;
    logic w_head;
    logic w_push;
    logic w_pop;
    logic w_err_set;

    // Command routing, response selection and error detection.
    always_comb begin
        w_sel   = cmd_function_id[FUNC_SEL_BIT];
        // Counter is held at zero in reset, so full reads 0 and empty reads 1.
        w_full  = (r_cnt == CNT_W'(OUTSTANDING_DEPTH));
        w_empty = (r_cnt == '0);
        w_head  = r_tag[r_rd_ptr];

        // Command side is also gated by reset so no handshake is offered
        // to the units while the tag FIFO is being cleared.
        accel_cmd_valid = cmd_valid & ~w_sel & ~w_full & ~reset;
        user_cmd_valid  = cmd_valid &  w_sel & ~w_full & ~reset;
        cmd_ready       = ~w_full & ~reset & (w_sel ? user_cmd_ready : accel_cmd_ready);

        rsp_valid       = ~w_empty & (w_head ? user_rsp_valid : accel_rsp_valid);
        rsp_outputs_0   = w_empty ? 32'd0 : (w_head ? user_rsp_outputs_0 : accel_rsp_outputs_0);
        accel_rsp_ready = rsp_ready & ~w_empty & ~w_head;
        user_rsp_ready  = rsp_ready & ~w_empty &  w_head;

        w_push = cmd_valid & cmd_ready;
        w_pop  = rsp_valid & rsp_ready;

        // A unit responding while not at the head (or with nothing pending).
        w_err_set = (accel_rsp_valid & (w_empty |  w_head)) |
                    (user_rsp_valid  & (w_empty | ~w_head));

        outstanding_cnt    = r_cnt;
        err_unexpected_rsp = r_err;
    end

    // Tag storage and write pointer advance on each accepted command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tag    <= '0;
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_tag[r_wr_ptr] <= w_sel;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
        end
    end

    // Read pointer advances on each response delivered to the CPU.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Outstanding count: push and pop in the same cycle cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Sticky error flag; clear wins over a simultaneous set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (err_clear) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire
